reg_file_2r1w: RTL and testbench

//  Parametrised register file: one write port, two independent read ports, registered reads.
//  A hardware init sequencer sweeps every entry to RESET_VAL after reset, so no reset fan-out
//  to the storage array is needed.

---
 rtl/reg_file_2r1w.sv | 121 ++++++++++++
 tb/tb_reg_file_2r1w.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_2r1w.sv
// Register file with one write port and two registered read ports; an init sweep clears every entry after reset.
// Optional write-through on read/write address collision: define RF_WR_BYPASS_EN.
module reg_file_2r1w #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 3,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Wr_Enable,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Rd0_Enable,
  input  logic [ADDR_W-1:0] Rd0_Addr,
  output logic [DATA_W-1:0] Rd0_Data,
  output logic              Rd0_Valid,
  input  logic              Rd1_Enable,
  input  logic [ADDR_W-1:0] Rd1_Addr,
  output logic [DATA_W-1:0] Rd1_Data,
  output logic              Rd1_Valid,
  output logic              Busy,
  output logic              Req_Err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W:0]     r_init_ptr;
  logic                r_req_err;
  logic                w_busy;
  logic                w_init_we;
  logic                w_ready;
  logic                w_wr_we;
  logic                w_any_req;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [1:0]          w_rd_en;
  logic [ADDR_W-1:0]   w_rd_addr [2];
  logic [DATA_W-1:0]   r_rd_data [2];
  logic [1:0]          r_rd_valid;

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_INIT;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && r_init_ptr == LAST_IDX) w_state_next = ST_READY;
  end

  // FSM: outputs
  always_comb begin
    w_busy    = (r_state == ST_INIT);
    w_ready   = (r_state == ST_READY) && !RST;
    w_init_we = w_busy && !RST;
  end

  assign w_wr_we   = w_ready && Wr_Enable;
  assign w_any_req = Wr_Enable || Rd0_Enable || Rd1_Enable;

  always_ff @(posedge CLK) begin
    if (RST)                    r_init_ptr <= '0;
    else if (r_state == ST_INIT) r_init_ptr <= r_init_ptr + PTR_ONE;
  end

  // A request coincident with reset is dropped silently.
  always_ff @(posedge CLK) begin
    if (RST) r_req_err <= 1'b0;
    else     r_req_err <= w_busy && w_any_req;
  end

  // Storage has no reset; the sweep and user writes share the single write port.
  always_ff @(posedge CLK) begin
    if (w_init_we)    r_mem[r_init_ptr[ADDR_W-1:0]] <= RESET_VAL;
    else if (w_wr_we) r_mem[Wr_Addr] <= Wr_Data;
  end

  assign w_rd_en      = {Rd1_Enable, Rd0_Enable};
  assign w_rd_addr[0] = Rd0_Addr;
  assign w_rd_addr[1] = Rd1_Addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic w_bypass;
`ifdef RF_WR_BYPASS_EN
      assign w_bypass = w_wr_we && (Wr_Addr == w_rd_addr[gi]);
`else
      assign w_bypass = 1'b0;
`endif
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_rd_data[gi]  <= '0;
          r_rd_valid[gi] <= 1'b0;
        end else begin
          r_rd_valid[gi] <= w_ready && w_rd_en[gi];
          if (w_ready && w_rd_en[gi]) begin
            if (w_bypass) r_rd_data[gi] <= Wr_Data;
            else          r_rd_data[gi] <= r_mem[w_rd_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign Rd0_Data  = r_rd_data[0];
  assign Rd1_Data  = r_rd_data[1];
  assign Rd0_Valid = r_rd_valid[0];
  assign Rd1_Valid = r_rd_valid[1];
  assign Busy      = w_busy;
  assign Req_Err   = r_req_err;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w; expected read data is queued on issue and popped when read back.
module tb_reg_file_2r1w;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Wr_Enable = 1'b0;
  logic [2:0]  Wr_Addr = '0;
  logic [15:0] Wr_Data = '0;
  logic        Rd0_Enable = 1'b0;
  logic [2:0]  Rd0_Addr = '0;
  logic [15:0] Rd0_Data;
  logic        Rd0_Valid;
  logic        Rd1_Enable = 1'b0;
  logic [2:0]  Rd1_Addr = '0;
  logic [15:0] Rd1_Data;
  logic        Rd1_Valid;
  logic        Busy;
  logic        Req_Err;

  int errors = 0;
  int checks = 0;
  logic [15:0] model [8];
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] exp0;
  logic [15:0] exp1;

  reg_file_2r1w #(.DATA_W(16), .ADDR_W(3), .RESET_VAL(16'h0000)) dut (
    .CLK(CLK), .RST(RST),
    .Wr_Enable(Wr_Enable), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data),
    .Rd0_Enable(Rd0_Enable), .Rd0_Addr(Rd0_Addr), .Rd0_Data(Rd0_Data), .Rd0_Valid(Rd0_Valid),
    .Rd1_Enable(Rd1_Enable), .Rd1_Addr(Rd1_Addr), .Rd1_Data(Rd1_Data), .Rd1_Valid(Rd1_Valid),
    .Busy(Busy), .Req_Err(Req_Err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Inputs change right after a falling edge; outputs are sampled at the next falling edge.
  task automatic step();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    Wr_Enable = 1'b0; Rd0_Enable = 1'b0; Rd1_Enable = 1'b0;
  endtask

  // Releases reset and counts sampled cycles with Busy high (bounded).
  task automatic release_and_count(output int cnt);
    RST = 1'b0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  task automatic test_reset();
    int cnt;
    RST = 1'b1;
    idle_inputs();
    step(); step();
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", Busy); end
    checks++;
    if ({Rd0_Valid, Rd1_Valid, Req_Err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {Rd0_Valid, Rd1_Valid, Req_Err});
    end
    checks++;
    if (Rd0_Data !== 16'h0000 || Rd1_Data !== 16'h0000) begin
      errors++; $display("FAIL reset_data: got %h/%h expected 0000/0000", Rd0_Data, Rd1_Data);
    end
    release_and_count(cnt);
    checks++;
    if (cnt !== 8) begin errors++; $display("FAIL init_busy_cycles: got %0d expected 8", cnt); end
    $display("reset/init: busy cycles=%0d", cnt);
  endtask

  // Back-to-back reads of every entry on both ports (port 1 walks downward).
  task automatic test_read_all(input string tag);
    for (int a = 0; a < 8; a++) begin
      Rd0_Enable = 1'b1; Rd0_Addr = 3'(a);
      Rd1_Enable = 1'b1; Rd1_Addr = 3'(7 - a);
      q0.push_back(model[a]);
      q1.push_back(model[7 - a]);
      step();
      exp0 = q0.pop_front();
      exp1 = q1.pop_front();
      checks++;
      if (Rd0_Valid !== 1'b1 || Rd0_Data !== exp0) begin
        errors++; $display("FAIL %s_rd0[%0d]: got v=%b %h expected v=1 %h", tag, a, Rd0_Valid, Rd0_Data, exp0);
      end
      checks++;
      if (Rd1_Valid !== 1'b1 || Rd1_Data !== exp1) begin
        errors++; $display("FAIL %s_rd1[%0d]: got v=%b %h expected v=1 %h", tag, 7 - a, Rd1_Valid, Rd1_Data, exp1);
      end
      $display("%s: rd0@%0d=%h rd1@%0d=%h", tag, a, Rd0_Data, 7 - a, Rd1_Data);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write_read();
    Wr_Enable = 1'b1; Wr_Addr = 3'd3; Wr_Data = 16'h1234; model[3] = 16'h1234;
    step();
    Wr_Addr = 3'd5; Wr_Data = 16'hBEEF; model[5] = 16'hBEEF;
    step();
    Wr_Enable = 1'b0;
    Rd0_Enable = 1'b1; Rd0_Addr = 3'd3; q0.push_back(model[3]);
    Rd1_Enable = 1'b1; Rd1_Addr = 3'd5; q1.push_back(model[5]);
    step();
    idle_inputs();
    exp0 = q0.pop_front();
    exp1 = q1.pop_front();
    checks++;
    if (Rd0_Valid !== 1'b1 || Rd0_Data !== exp0) begin
      errors++; $display("FAIL wr_rd0: got v=%b %h expected v=1 %h", Rd0_Valid, Rd0_Data, exp0);
    end
    checks++;
    if (Rd1_Valid !== 1'b1 || Rd1_Data !== exp1) begin
      errors++; $display("FAIL wr_rd1: got v=%b %h expected v=1 %h", Rd1_Valid, Rd1_Data, exp1);
    end
    $display("write/read: rd0=%h rd1=%h", Rd0_Data, Rd1_Data);
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (Rd0_Valid !== 1'b0 || Rd0_Data !== 16'h1234) begin
        errors++; $display("FAIL hold[%0d]: got v=%b %h expected v=0 1234", i, Rd0_Valid, Rd0_Data);
      end
      $display("hold[%0d]: rd0=%h valid=%b", i, Rd0_Data, Rd0_Valid);
    end
  endtask

  task automatic test_same_addr();
    Rd0_Enable = 1'b1; Rd0_Addr = 3'd5; q0.push_back(model[5]);
    Rd1_Enable = 1'b1; Rd1_Addr = 3'd5; q1.push_back(model[5]);
    step();
    idle_inputs();
    exp0 = q0.pop_front();
    exp1 = q1.pop_front();
    checks++;
    if (Rd0_Data !== exp0 || Rd1_Data !== exp1 || Rd0_Valid !== 1'b1 || Rd1_Valid !== 1'b1) begin
      errors++; $display("FAIL same_addr: got %h/%h v=%b%b expected %h/%h v=11", Rd0_Data, Rd1_Data, Rd0_Valid, Rd1_Valid, exp0, exp1);
    end
    $display("same addr: rd0=%h rd1=%h", Rd0_Data, Rd1_Data);
  endtask

  task automatic test_collision();
    Wr_Enable = 1'b1; Wr_Addr = 3'd2; Wr_Data = 16'h00AA; model[2] = 16'h00AA;
    step();
    Wr_Data = 16'h5555;
    Rd0_Enable = 1'b1; Rd0_Addr = 3'd2;
`ifdef RF_WR_BYPASS_EN
    q0.push_back(16'h5555);
`else
    q0.push_back(model[2]);
`endif
    model[2] = 16'h5555;
    step();
    Wr_Enable = 1'b0;
    exp0 = q0.pop_front();
    checks++;
    if (Rd0_Valid !== 1'b1 || Rd0_Data !== exp0) begin
      errors++; $display("FAIL collision: got v=%b %h expected v=1 %h", Rd0_Valid, Rd0_Data, exp0);
    end
    $display("collision: rd0=%h", Rd0_Data);
    q0.push_back(model[2]);
    step();
    Rd0_Enable = 1'b0;
    exp0 = q0.pop_front();
    checks++;
    if (Rd0_Valid !== 1'b1 || Rd0_Data !== exp0) begin
      errors++; $display("FAIL collision_after: got v=%b %h expected v=1 %h", Rd0_Valid, Rd0_Data, exp0);
    end
    $display("collision follow-up: rd0=%h", Rd0_Data);
  endtask

  task automatic test_busy_req();
    int cnt;
    RST = 1'b1;
    step();
    RST = 1'b0;
    Wr_Enable = 1'b1; Wr_Addr = 3'd1; Wr_Data = 16'hFFFF;
    Rd0_Enable = 1'b1; Rd0_Addr = 3'd1;
    step();
    idle_inputs();
    checks++;
    if (Req_Err !== 1'b1 || Rd0_Valid !== 1'b0) begin
      errors++; $display("FAIL busy_req_err: got err=%b v=%b expected err=1 v=0", Req_Err, Rd0_Valid);
    end
    step();
    checks++;
    if (Req_Err !== 1'b0) begin errors++; $display("FAIL busy_req_pulse: got %b expected 0", Req_Err); end
    $display("busy request: req_err pulse seen");
    cnt = 0;
    while (Busy === 1'b1 && cnt < 40) begin cnt++; step(); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL busy_req_done: got busy=%b expected 0", Busy); end
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    Rd0_Enable = 1'b1; Rd0_Addr = 3'd1; q0.push_back(model[1]);
    step();
    Rd0_Enable = 1'b0;
    exp0 = q0.pop_front();
    checks++;
    if (Rd0_Valid !== 1'b1 || Rd0_Data !== exp0) begin
      errors++; $display("FAIL busy_req_rd1: got v=%b %h expected v=1 %h", Rd0_Valid, Rd0_Data, exp0);
    end
    $display("busy request: read @1=%h", Rd0_Data);
  endtask

  task automatic test_reset_mid();
    int cnt;
    Wr_Enable = 1'b1; Wr_Addr = 3'd4; Wr_Data = 16'h7777;
    step();
    Wr_Enable = 1'b0;
    // Request coincident with reset: dropped, no Req_Err.
    RST = 1'b1; Rd0_Enable = 1'b1; Rd0_Addr = 3'd4;
    step();
    Rd0_Enable = 1'b0;
    checks++;
    if (Req_Err !== 1'b0 || Rd0_Valid !== 1'b0) begin
      errors++; $display("FAIL rst_coincident: got err=%b v=%b expected 0 0", Req_Err, Rd0_Valid);
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) step();
    RST = 1'b1;
    step();
    release_and_count(cnt);
    checks++;
    if (cnt !== 8) begin errors++; $display("FAIL mid_reset_busy: got %0d expected 8", cnt); end
    $display("reset mid-sweep: busy cycles=%0d", cnt);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    test_reset();
    test_read_all("init_read");
    test_write_read();
    test_hold();
    test_same_addr();
    test_collision();
    test_busy_req();
    test_reset_mid();
    test_read_all("mid_reset_read");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
